dmem_access_ctrl: RTL and testbench
===================================

# dmem_access_ctrl

Data-memory access sequencer for the MEM stage of the five-stage MIPS pipeline. Decodes the instruction held in the EX/MEM register, drives a variable-latency data memory over a req/ack handshake, and freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) until the access completes. It also forms byte enables, store-data lane replication and load extension, and flags misaligned accesses and memory timeouts.

## Interface
- TIMEOUT_CYCLES, 255: maximum REQ cycles without mem_ack before abort; legal range 1..65535.
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- IR_MEM  in  32  instruction in the EX/MEM register.
- AO_MEM  in  32  ALU output, the effective address.
- RD2_MEM  in  32  store source register value.
- mem_req  out  1  access request, held until ack.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req.
- mem_addr  out  32  word-aligned address, {AO_MEM[31:2],2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian).
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle.
- mem_rdata  in  32  raw read word.
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- mem_bubble  out  1  MEM/WB loads a NOP this cycle.
- load_data  out  32  extended load result for MEM/WB.
- load_valid  out  1  load_data valid (one cycle).
- addr_err  out  1  misaligned access detected (one cycle).
- timeout_err  out  1  access aborted by timeout (one cycle).

## Operation
- Decoded ops (opcode IR_MEM[31:26]): lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011. Every other opcode is a non-memory instruction.
- Misalignment rules: lw/sw require AO[1:0]==0; lh/lhu/sh require AO[0]==0.
- A misaligned op raises addr_err combinationally in IDLE. It issues no request and no stall, and the instruction advances.
- Byte enables: sb gives 1<<AO[1:0]. sh gives 0011 or 1100, selected by AO[1]. sw gives 1111. Loads give 1111.
- Store data: sb gives {4{RD2[7:0]}}, sh gives {2{RD2[15:0]}}, sw gives RD2.
- Load extension: the lane is selected by AO[1:0] (sb/lb) or AO[1] (half). lb/lh sign-extend; lbu/lhu zero-extend.
- FSM states: IDLE, REQ, DONE.
- IDLE → REQ on an aligned memory op. On that edge, register mem_addr/mem_we/mem_wdata/mem_be, the op type and AO[1:0], and clear the timeout counter.
- REQ → DONE on mem_ack. On that edge, register the extended mem_rdata into load_data for loads.
- REQ → DONE when the counter reaches TIMEOUT_CYCLES-1 with no ack. load_data is 0 and timeout_err pulses during DONE.
- DONE → IDLE unconditionally.
- stall = (IDLE && aligned memory op) || REQ. mem_bubble = stall.
- mem_req = REQ, registered. mem_ack is ignored in IDLE and DONE.
- load_valid is 1 in DONE for loads only, including on timeout.

## Timing
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, load_data 0, load_valid 0, timeout_err 0, counter 0.
- After reset, stall and addr_err follow IR_MEM decode, because IR_MEM is also 0 (NOP) after reset.
- Minimum latency with zero-wait ack:
  - cycle 0: IDLE detect, stall=1.
  - cycle 1: REQ, mem_req=1, ack.
  - cycle 2: DONE, stall=0, load_valid=1. EX/MEM advances at the end of cycle 2.
- A memory op with ack N cycles after mem_req rises occupies N+3 cycles in MEM. Back-to-back memory ops each pay this cost.
- mem_addr, mem_we, mem_wdata and mem_be are stable for every REQ cycle.
- The same instruction is never issued twice: DONE has no IDLE detect.
- Timeout: the counter increments each REQ cycle without ack. If ack arrives on the terminal count cycle, the ack wins and timeout_err stays 0.
- Reset asserted mid-REQ: mem_req drops at the next edge, state goes IDLE, and no load_valid or timeout_err is produced.

## Structure
- Shared package mips_pkg holds:
  - opcode localparams (OP_LB … OP_SW);
  - byte-enable constants;
  - state enum {S_IDLE, S_REQ, S_DONE}.
- Sub-module dmem_lane_align is purely combinational. It performs store-lane replication, byte-enable generation, load extension and the misalignment check. It is instantiated once.
- The FSM and timeout counter live in dmem_access_ctrl.

## Test plan
- lw, AO=0x0000_1004, memory acks immediately with 0x8899_AABB: mem_addr=0x1004 and be=1111 in cycle 1; load_data=0x8899_AABB with load_valid in cycle 2; stall high exactly cycles 0–1.
- lb at AO=…03 with rdata 0x80FF_0000 → load_data=0xFFFF_FF80. lbu at the same address → 0x0000_0080. lh at AO=…02 → 0xFFFF_80FF.
- sh, AO=0x22, RD2=0x1234_5678, ack after 4 cycles: wdata=0x5678_5678 and be=1100, held stable all REQ cycles; stall high 6 cycles; load_valid stays 0.
- lw at AO=…02: addr_err=1 for one cycle, mem_req never rises, stall stays 0.
- TIMEOUT_CYCLES=8 with no ack: mem_req high exactly 8 cycles, then DONE with timeout_err=1, load_data=0, and stall released. Repeat with ack on the 8th REQ cycle: no timeout_err.
- Reset pulsed on the 2nd REQ cycle of a wait: mem_req=0 next cycle, state IDLE, no load_valid; the next lw then completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg - definitions shared by the MEM-stage data-memory access logic.
//   * MIPS load/store opcodes (IR[31:26])
//   * byte-enable constants
//   * access sequencer state encoding
//   * small opcode classification helpers
package mips_pkg;

  // Load/store opcodes
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // Byte enables, bit i = byte lane i (little-endian)
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  // Access sequencer states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True for any of the eight decoded load/store opcodes
  function automatic logic op_is_mem(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
      OP_SB, OP_SH, OP_SW: op_is_mem = 1'b1;
      default:             op_is_mem = 1'b0;
    endcase
  endfunction

  // True for the five load opcodes
  function automatic logic op_is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_is_load = 1'b1;
      default:                             op_is_load = 1'b0;
    endcase
  endfunction

  // True for the three store opcodes
  function automatic logic op_is_store(input logic [5:0] op);
    case (op)
      OP_SB, OP_SH, OP_SW: op_is_store = 1'b1;
      default:             op_is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align - combinational byte-lane handling for data-memory accesses.
// Store side works on the instruction currently in EX/MEM; load side works on
// the op/offset captured when the request was issued, so the load result does
// not depend on EX/MEM while the access is outstanding.
// Ports:
//   i_op         opcode of the instruction in EX/MEM
//   i_ao_lo      effective address bits [1:0] of that instruction
//   i_rd2        store source value
//   i_ld_op      opcode captured at request issue
//   i_ld_off     address bits [1:0] captured at request issue
//   i_rdata      raw read word from memory
//   o_is_mem     i_op is a decoded load/store
//   o_misaligned i_op violates its natural alignment
//   o_be         byte enables for i_op
//   o_wdata      lane-replicated store data for i_op
//   o_load_ext   extended load result for i_ld_op
module dmem_lane_align (
  input  logic [5:0]  i_op,
  input  logic [1:0]  i_ao_lo,
  input  logic [31:0] i_rd2,
  input  logic [5:0]  i_ld_op,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic        o_is_mem,
  output logic        o_misaligned,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_ext
);
  import mips_pkg::*;

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign o_is_mem = op_is_mem(i_op);

  // Alignment check: words need offset 0, halves need an even offset
  always_comb begin
    o_misaligned = 1'b0;
    case (i_op)
      OP_LW, OP_SW:          o_misaligned = (i_ao_lo != 2'b00);
      OP_LH, OP_LHU, OP_SH:  o_misaligned = i_ao_lo[0];
      default:               o_misaligned = 1'b0;
    endcase
  end

  // Byte-enable generation; loads always fetch the whole word
  always_comb begin
    o_be = BE_NONE;
    case (i_op)
      OP_SB:                               o_be = BE_BYTE0 << i_ao_lo;
      OP_SH:                               o_be = i_ao_lo[1] ? BE_HI_HALF : BE_LO_HALF;
      OP_SW, OP_LB, OP_LH, OP_LW,
      OP_LBU, OP_LHU:                      o_be = BE_ALL;
      default:                             o_be = BE_NONE;
    endcase
  end

  // Store data replicated across every lane so memory picks it up via o_be
  always_comb begin
    o_wdata = 32'd0;
    case (i_op)
      OP_SB:   o_wdata = {4{i_rd2[7:0]}};
      OP_SH:   o_wdata = {2{i_rd2[15:0]}};
      OP_SW:   o_wdata = i_rd2;
      default: o_wdata = 32'd0;
    endcase
  end

  // Byte lane selection for loads
  always_comb begin
    w_byte = 8'd0;
    case (i_ld_off)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = 8'd0;
    endcase
  end

  // Half lane selection for loads
  always_comb begin
    w_half = 16'd0;
    if (i_ld_off[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
  end

  // Sign or zero extension by load type
  always_comb begin
    o_load_ext = 32'd0;
    case (i_ld_op)
      OP_LB:   o_load_ext = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_load_ext = {24'd0, w_byte};
      OP_LH:   o_load_ext = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_load_ext = {16'd0, w_half};
      OP_LW:   o_load_ext = i_rdata;
      default: o_load_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl - MEM-stage data-memory access sequencer.
// Decodes the EX/MEM instruction, runs one req/ack transaction per aligned
// load/store, stalls the upstream pipeline while it is in flight, and aborts
// an access that waits TIMEOUT_CYCLES request cycles without an ack.
// Ports:
//   CLK, reset        clock; synchronous active-high reset
//   IR_MEM, AO_MEM    EX/MEM instruction and effective address
//   RD2_MEM           store source value
//   mem_req/we/addr/wdata/be   registered request to data memory
//   mem_ack, mem_rdata         memory completion and read word
//   stall, mem_bubble          freeze upstream / insert NOP into MEM/WB
//   load_data, load_valid      extended load result (one-cycle valid)
//   addr_err                   misaligned access (combinational, IDLE only)
//   timeout_err                access aborted by timeout (one cycle)
module dmem_access_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [31:0] IR_MEM,
  input  logic [31:0] AO_MEM,
  input  logic [31:0] RD2_MEM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        mem_bubble,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_err,
  output logic        timeout_err
);
  import mips_pkg::*;

  // Counter value on the last request cycle allowed before abort
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [15:0] r_tmo_cnt;
  logic [5:0]  r_op;
  logic [1:0]  r_off;
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [31:0] r_load_data;
  logic        r_load_valid;
  logic        r_timeout_err;

  logic        w_is_mem;
  logic        w_misaligned;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_ext;
  logic        w_issue;
  logic        w_op_is_load;
  logic        w_unused_ir;

  // Only the opcode field of the instruction matters here
  assign w_unused_ir = ^IR_MEM[25:0];

  dmem_lane_align u_lane_align (
    .i_op         (IR_MEM[31:26]),
    .i_ao_lo      (AO_MEM[1:0]),
    .i_rd2        (RD2_MEM),
    .i_ld_op      (r_op),
    .i_ld_off     (r_off),
    .i_rdata      (mem_rdata),
    .o_is_mem     (w_is_mem),
    .o_misaligned (w_misaligned),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_ext   (w_load_ext)
  );

  // Detection happens only in IDLE, so the instruction still sitting in
  // EX/MEM during DONE is not issued a second time.
  assign w_issue      = (r_state == S_IDLE) && w_is_mem && !w_misaligned;
  assign addr_err     = (r_state == S_IDLE) && w_is_mem && w_misaligned;
  assign stall        = w_issue || (r_state == S_REQ);
  assign mem_bubble   = stall;
  assign w_op_is_load = op_is_load(r_op);

  assign mem_req     = r_mem_req;
  assign mem_we      = r_mem_we;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_be      = r_mem_be;
  assign load_data   = r_load_data;
  assign load_valid  = r_load_valid;
  assign timeout_err = r_timeout_err;

  // Access sequencer: state, request registers, timeout counter, results
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_tmo_cnt     <= 16'd0;
      r_op          <= 6'd0;
      r_off         <= 2'd0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= 32'd0;
      r_mem_wdata   <= 32'd0;
      r_mem_be      <= 4'd0;
      r_load_data   <= 32'd0;
      r_load_valid  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_load_valid  <= 1'b0;
          r_timeout_err <= 1'b0;
          if (w_issue) begin
            // Request fields are frozen here for the whole REQ phase
            r_state     <= S_REQ;
            r_mem_req   <= 1'b1;
            r_mem_we    <= op_is_store(IR_MEM[31:26]);
            r_mem_addr  <= {AO_MEM[31:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_be    <= w_be;
            r_op        <= IR_MEM[31:26];
            r_off       <= AO_MEM[1:0];
            r_tmo_cnt   <= 16'd0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            // Ack wins even on the terminal count cycle
            r_state       <= S_DONE;
            r_mem_req     <= 1'b0;
            r_load_data   <= w_op_is_load ? w_load_ext : 32'd0;
            r_load_valid  <= w_op_is_load;
            r_timeout_err <= 1'b0;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_state       <= S_DONE;
            r_mem_req     <= 1'b0;
            r_load_data   <= 32'd0;
            r_load_valid  <= w_op_is_load;
            r_timeout_err <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_state       <= S_IDLE;
          r_load_valid  <= 1'b0;
          r_timeout_err <= 1'b0;
        end
        default: begin
          r_state       <= S_IDLE;
          r_mem_req     <= 1'b0;
          r_load_valid  <= 1'b0;
          r_timeout_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl - directed and randomized bench for dmem_access_ctrl.
// Expected values come from an arithmetic model of the load/store rules.
module tb_dmem_access_ctrl;

  localparam int TMO = 8;

  localparam logic [5:0] T_LB  = 6'b100000;
  localparam logic [5:0] T_LH  = 6'b100001;
  localparam logic [5:0] T_LW  = 6'b100011;
  localparam logic [5:0] T_LBU = 6'b100100;
  localparam logic [5:0] T_LHU = 6'b100101;
  localparam logic [5:0] T_SB  = 6'b101000;
  localparam logic [5:0] T_SH  = 6'b101001;
  localparam logic [5:0] T_SW  = 6'b101011;

  logic        CLK = 1'b0;
  logic        reset;
  logic [31:0] IR_MEM, AO_MEM, RD2_MEM, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, stall, mem_bubble, load_valid, addr_err, timeout_err;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .reset(reset), .IR_MEM(IR_MEM), .AO_MEM(AO_MEM), .RD2_MEM(RD2_MEM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall),
    .mem_bubble(mem_bubble), .load_data(load_data), .load_valid(load_valid),
    .addr_err(addr_err), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size in bytes (0 = not a memory op)
  function automatic int f_size(input logic [5:0] op);
    case (op)
      T_LB, T_LBU, T_SB: return 1;
      T_LH, T_LHU, T_SH: return 2;
      T_LW, T_SW:        return 4;
      default:           return 0;
    endcase
  endfunction

  function automatic bit f_load(input logic [5:0] op);
    return (op == T_LB) || (op == T_LH) || (op == T_LW) || (op == T_LBU) || (op == T_LHU);
  endfunction

  function automatic bit f_signed(input logic [5:0] op);
    return (op == T_LB) || (op == T_LH);
  endfunction

  function automatic logic [31:0] f_be(input logic [5:0] op, input logic [31:0] ao);
    int sz = f_size(op);
    int off = int'(ao % 32'd4);
    if (f_load(op)) return 32'hF;
    return 32'(((1 << sz) - 1) << off);
  endfunction

  function automatic logic [31:0] f_wdata(input logic [5:0] op, input logic [31:0] rd2);
    int sz = f_size(op);
    if (sz == 1) return (rd2 % 32'd256) * 32'h0101_0101;
    if (sz == 2) return (rd2 % 32'd65536) * 32'h0001_0001;
    return rd2;
  endfunction

  function automatic logic [31:0] f_ldval(input logic [5:0] op, input logic [31:0] ao,
                                          input logic [31:0] rdata);
    int     sz = f_size(op);
    int     off = int'(ao % 32'd4);
    longint span = longint'(1) << (8 * sz);
    longint v = (longint'(rdata) >> (8 * off)) % span;
    if (f_signed(op) && (v >= span / 2)) v = v - span;
    return 32'(v);
  endfunction

  // One instruction through MEM; ack_dly = REQ cycle index of the ack, -1 = none
  task automatic do_op(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] rd2,
                       input logic [31:0] rdata, input int ack_dly);
    int sz = f_size(op);
    bit mem = (sz != 0);
    bit mis = mem && ((ao % 32'(sz)) != 32'd0);
    bit ld  = f_load(op);
    bit tmo = (ack_dly < 0) || (ack_dly >= TMO);
    int nreq = tmo ? TMO : ack_dly + 1;

    @(posedge CLK); #1;
    IR_MEM = {op, 26'($urandom)}; AO_MEM = ao; RD2_MEM = rd2;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    chk("idle_stall", 32'(stall), 32'(mem && !mis));
    chk("idle_bubble", 32'(mem_bubble), 32'(mem && !mis));
    chk("idle_addr_err", 32'(addr_err), 32'(mis));
    chk("idle_req", 32'(mem_req), 32'd0);
    if (!mem || mis) return;

    for (int k = 0; k < nreq; k++) begin
      @(posedge CLK); #1;
      mem_ack = (k == ack_dly);
      mem_rdata = (k == ack_dly) ? rdata : $urandom;
      #1;
      chk("req_mem_req", 32'(mem_req), 32'd1);
      chk("req_stall", 32'(stall), 32'd1);
      chk("req_addr", mem_addr, {ao[31:2], 2'b00});
      chk("req_we", 32'(mem_we), 32'(!ld));
      chk("req_be", 32'(mem_be), f_be(op, ao));
      if (!ld) chk("req_wdata", mem_wdata, f_wdata(op, rd2));
      chk("req_addr_err", 32'(addr_err), 32'd0);
    end

    @(posedge CLK); #1;
    mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
    #1;
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_req", 32'(mem_req), 32'd0);
    chk("done_addr_err", 32'(addr_err), 32'd0);
    chk("done_load_valid", 32'(load_valid), 32'(ld));
    chk("done_timeout", 32'(timeout_err), 32'(tmo));
    if (ld) chk("done_load_data", load_data, tmo ? 32'd0 : f_ldval(op, ao, rdata));
  endtask

  logic [5:0] ops [12];

  initial begin
    ops = '{T_LB, T_LH, T_LW, T_LBU, T_LHU, T_SB, T_SH, T_SW,
            6'b000000, 6'b001000, 6'b100010, 6'b101110};
    reset = 1'b1; IR_MEM = 32'd0; AO_MEM = 32'd0; RD2_MEM = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge CLK);
    #1; reset = 1'b0; #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_load_valid", 32'(load_valid), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_addr_err", 32'(addr_err), 32'd0);

    // Directed cases
    do_op(T_LW,  32'h0000_1004, 32'd0, 32'h8899_AABB, 0);
    do_op(T_LB,  32'h0000_2003, 32'd0, 32'h80FF_0000, 0);
    do_op(T_LBU, 32'h0000_2003, 32'd0, 32'h80FF_0000, 1);
    do_op(T_LH,  32'h0000_2002, 32'd0, 32'h80FF_0000, 0);
    do_op(T_SH,  32'h0000_0022, 32'h1234_5678, 32'd0, 4);
    do_op(T_SB,  32'h0000_0031, 32'hCAFE_BEA5, 32'd0, 2);
    do_op(T_SW,  32'h0000_0040, 32'hDEAD_BEEF, 32'd0, 0);
    do_op(T_LW,  32'h0000_0002, 32'd0, 32'd0, 0);
    do_op(T_SH,  32'h0000_0013, 32'd0, 32'd0, 0);
    do_op(T_LHU, 32'h0000_0006, 32'd0, 32'hBEEF_1234, -1);
    do_op(T_LW,  32'h0000_0100, 32'd0, 32'h1357_9BDF, TMO - 1);
    do_op(T_SW,  32'h0000_0104, 32'h0F0F_0F0F, 32'd0, -1);

    // Reset on the 2nd REQ cycle of a waiting load
    @(posedge CLK); #1;
    IR_MEM = {T_LW, 26'd0}; AO_MEM = 32'h0000_0040; mem_ack = 1'b0; #1;
    chk("rr_detect_stall", 32'(stall), 32'd1);
    @(posedge CLK); #1; mem_ack = 1'b0; #1;
    chk("rr_req1", 32'(mem_req), 32'd1);
    @(posedge CLK); #1; reset = 1'b1; mem_ack = 1'b0; #1;
    chk("rr_req2", 32'(mem_req), 32'd1);
    @(posedge CLK); #1; reset = 1'b0; IR_MEM = 32'd0; #1;
    chk("rr_req_drop", 32'(mem_req), 32'd0);
    chk("rr_stall", 32'(stall), 32'd0);
    chk("rr_load_valid", 32'(load_valid), 32'd0);
    chk("rr_timeout", 32'(timeout_err), 32'd0);
    @(posedge CLK); #2;
    chk("rr_load_valid2", 32'(load_valid), 32'd0);
    chk("rr_req_idle", 32'(mem_req), 32'd0);
    do_op(T_LW, 32'h0000_0040, 32'd0, 32'h2468_ACE0, 1);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      logic [5:0]  op;
      logic [31:0] ao;
      int          sz, r, dly;
      op = ops[$urandom_range(0, 11)];
      ao = $urandom;
      sz = f_size(op);
      if ((sz != 0) && ($urandom_range(0, 3) != 0)) ao = ao - (ao % 32'(sz));
      r = $urandom_range(0, 9);
      dly = (r == 9) ? -1 : ((r == 8) ? TMO - 1 : r % 4);
      do_op(op, ao, $urandom, $urandom, dly);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
